// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction-fetch stage.
//
//   Contents:
//     DATA_WIDTH_DEF  default datapath width (PC, instruction, PROGCOUNT)
//     RESET_VECTOR    PC loaded on reset
//     PC_STEP         sequential PC increment in bytes
//     PC_OFFSET       ARM visible-PC offset added to IFID_PC for PROGCOUNT
//     NOP_INSTR       bubble instruction (MOV R0,R0) placed in IR on reset/flush
//     fetch_state_t   IF/ID occupancy state: BUBBLE (no real instruction) or RUN
//     is_misaligned   helper: true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_VECTOR   = 32'h0000_0000;
    localparam int unsigned PC_STEP        = 4;
    localparam int unsigned PC_OFFSET      = 8;
    localparam logic [31:0] NOP_INSTR      = 32'hE1A0_0000;

    typedef enum logic {
        BUBBLE = 1'b0,
        RUN    = 1'b1
    } fetch_state_t;

    // Word alignment check on the two byte-offset bits of an address.
    function automatic logic is_misaligned(input logic [1:0] byte_ofs);
        return byte_ofs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
//   Program-counter flop with next-PC selection and optional branch-target
//   alignment check.
//
//   Next-PC priority at each posedge:
//     reset_n=0  -> RESET_VECTOR
//     br_taken=1 -> branch target (overrides a stall)
//     le=0       -> hold
//     otherwise  -> pc + PC_STEP (wraps modulo 2^DATA_WIDTH)
//
//   Optional feature (macro FETCH_ALIGN_CHECK_EN):
//     A taken branch to a non-word-aligned target loads the target with its
//     two low bits cleared and sets the sticky align_err flag, which only a
//     reset clears. Without the macro the target is loaded unmodified and the
//     align_err port does not exist.
//
//   Ports:
//     clk        in   1           clock
//     reset_n    in   1           synchronous reset, active-low
//     le         in   1           load enable; 0 = hold PC
//     br_taken   in   1           branch taken this cycle
//     br_target  in   DATA_WIDTH  branch target address
//     pc         out  DATA_WIDTH  current fetch address
//     align_err  out  1           sticky misaligned-target flag (macro only)
// -----------------------------------------------------------------------------
module pc_register
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = fetch_pkg::DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(fetch_pkg::RESET_VECTOR),
    parameter int unsigned           PC_STEP      = fetch_pkg::PC_STEP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  le,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                  align_err,
`endif
    output logic [DATA_WIDTH-1:0] pc
);

    logic [DATA_WIDTH-1:0] target_eff;
    logic [DATA_WIDTH-1:0] pc_seq;

    // Sequential increment; the carry out of the top bit is discarded so the
    // PC wraps from the last word back to address zero.
    assign pc_seq = pc + DATA_WIDTH'(PC_STEP);

`ifdef FETCH_ALIGN_CHECK_EN
    logic target_bad;

    always_comb begin
        target_bad = is_misaligned(br_target[1:0]);
        target_eff = {br_target[DATA_WIDTH-1:2], 2'b00};
    end
`else
    always_comb begin
        target_eff = br_target;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc <= RESET_VECTOR;
        end else if (br_taken) begin
            pc <= target_eff;
        end else if (le) begin
            pc <= pc_seq;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky: once a bad target has been seen, only reset clears the flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            align_err <= 1'b0;
        end else if (br_taken && target_bad) begin
            align_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage feeding register_file. Holds the program counter
//   (via pc_register), latches the fetched word into the IF/ID register and
//   drives PROGCOUNT = IFID_PC + PC_OFFSET so that R15 reads return the ARM
//   visible PC (address of the decoding instruction + 8).
//
//   Behaviour at each posedge, highest priority first:
//     RESET_N=0  : PC=RESET_VECTOR, IR=NOP, IFID_PC=0, state=BUBBLE
//     BR_TAKEN=1 : PC=BR_TARGET, IR=NOP, IFID_PC=0, state=BUBBLE (flush)
//     LE=0       : everything holds (stall)
//     otherwise  : PC+=PC_STEP, IR=INSTR_IN, IFID_PC=PC, state=RUN
//   VALID is a decode of the state (1 iff RUN).
//
//   Optional feature (macro FETCH_ALIGN_CHECK_EN): misaligned branch targets
//   are word-aligned on load and flagged on the sticky ALIGN_ERR output. The
//   ALIGN_ERR port exists only when the macro is defined.
//
//   Ports:
//     CLK        in   1           clock
//     RESET_N    in   1           synchronous reset, active-low
//     LE         in   1           load enable; 0 = stall
//     BR_TAKEN   in   1           branch resolved taken this cycle
//     BR_TARGET  in   DATA_WIDTH  branch target address
//     INSTR_IN   in   DATA_WIDTH  instruction memory data at PC_OUT
//     PC_OUT     out  DATA_WIDTH  current fetch address
//     IR         out  DATA_WIDTH  IF/ID instruction register
//     IFID_PC    out  DATA_WIDTH  address of the instruction in IR
//     PROGCOUNT  out  DATA_WIDTH  IFID_PC + PC_OFFSET (wrapping)
//     VALID      out  1           IR holds a real fetched instruction
//     ALIGN_ERR  out  1           sticky misaligned-target flag (macro only)
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = fetch_pkg::DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(fetch_pkg::RESET_VECTOR),
    parameter int unsigned           PC_STEP      = fetch_pkg::PC_STEP,
    parameter int unsigned           PC_OFFSET    = fetch_pkg::PC_OFFSET,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(fetch_pkg::NOP_INSTR)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  LE,
    input  logic                  BR_TAKEN,
    input  logic [DATA_WIDTH-1:0] BR_TARGET,
    input  logic [DATA_WIDTH-1:0] INSTR_IN,
    output logic [DATA_WIDTH-1:0] PC_OUT,
    output logic [DATA_WIDTH-1:0] IR,
    output logic [DATA_WIDTH-1:0] IFID_PC,
    output logic [DATA_WIDTH-1:0] PROGCOUNT,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                  ALIGN_ERR,
`endif
    output logic                  VALID
);

    fetch_state_t state;

    pc_register #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_VECTOR (RESET_VECTOR),
        .PC_STEP      (PC_STEP)
    ) u_pc_register (
        .clk       (CLK),
        .reset_n   (RESET_N),
        .le        (LE),
        .br_taken  (BR_TAKEN),
        .br_target (BR_TARGET),
`ifdef FETCH_ALIGN_CHECK_EN
        .align_err (ALIGN_ERR),
`endif
        .pc        (PC_OUT)
    );

    // IF/ID register and occupancy FSM. A taken branch squashes whatever was
    // fetched from the wrong path, so it loads the same bubble as reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N || BR_TAKEN) begin
            IR      <= NOP_INSTR;
            IFID_PC <= '0;
            state   <= BUBBLE;
        end else if (LE) begin
            IR      <= INSTR_IN;
            IFID_PC <= PC_OUT;
            state   <= RUN;
        end
    end

    assign VALID = (state == RUN);

    // ARM visible PC: two instructions ahead of the one in decode. Wraps.
    assign PROGCOUNT = IFID_PC + DATA_WIDTH'(PC_OFFSET);

endmodule
